// File: rtl/buffer_pkg.sv
// Shared constants and run-state encoding for the frame serializer/deserializer pair.
// Optional nibble parity output is enabled by defining BUFFER_DE_PARITY_EN.
package buffer_pkg;

    localparam int FRAME_BITS = 64;
    localparam int NIB_W      = 4;
    localparam int NIBS       = FRAME_BITS / NIB_W;
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam int NIB_SEL_W  = (NIBS > 1) ? $clog2(NIBS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } run_state_e;

    function automatic logic nib_parity(input logic [NIB_W-1:0] nib);
        return ^nib;
    endfunction

endpackage

// File: rtl/buffer_frame_cnt.sv
// Mod-FRAME_BITS frame position counter with a sticky run flag, started by ena.
// adv marks every edge that consumes a bit; wrap marks the last bit of a frame.
module buffer_frame_cnt
    import buffer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    output logic [CNT_W-1:0] cnt,
    output logic             adv,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);

    run_state_e state, state_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (adv) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // The start edge itself already carries bit 0, so adv is raised in IDLE too.
    always_comb begin
        state_nxt = state;
        adv       = 1'b0;
        case (state)
            IDLE: begin
                if (ena) begin
                    state_nxt = RUN;
                    adv       = 1'b1;
                end
            end
            RUN: begin
                adv = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign wrap = adv && (cnt == CNT_LAST);

endmodule

// File: rtl/buffer_de.sv
// Serial-to-parallel frame deserializer: captures 64-bit frames LSB-first and replays
// each completed frame as 16 nibbles during the next frame. Macro BUFFER_DE_PARITY_EN adds nib_par.
module buffer_de
    import buffer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             data_in,
    output logic [NIB_W-1:0] data_out,
    output logic             valid,
    output logic             frame_done
`ifdef BUFFER_DE_PARITY_EN
    ,
    output logic             nib_par
`endif
);

    localparam logic [CNT_W:0] NIBS_LIM = (CNT_W + 1)'(NIBS);

    logic [CNT_W-1:0]            cnt;
    logic                        adv;
    logic                        wrap;
    logic [FRAME_BITS-1:0]       cap;
    logic [NIBS-1:0][NIB_W-1:0]  hold;
    logic                        have_frame;
    logic                        out_win;
    logic [NIB_SEL_W-1:0]        nib_sel;

    buffer_frame_cnt u_frame_cnt (
        .clk  (clk),
        .rst  (rst),
        .ena  (ena),
        .cnt  (cnt),
        .adv  (adv),
        .wrap (wrap)
    );

    assign out_win = adv && have_frame && ({1'b0, cnt} < NIBS_LIM);
    assign nib_sel = cnt[NIB_SEL_W-1:0];

    // hold only changes on the wrap edge, so the replay window always reads a stable frame
    // while the next frame streams into cap.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap        <= '0;
            hold       <= '0;
            have_frame <= 1'b0;
            data_out   <= '0;
            valid      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid      <= 1'b0;
            frame_done <= 1'b0;
            if (adv) begin
                cap[cnt] <= data_in;
            end
            if (wrap) begin
                hold       <= {data_in, cap[FRAME_BITS-2:0]};
                frame_done <= 1'b1;
                have_frame <= 1'b1;
            end
            if (out_win) begin
                data_out <= hold[nib_sel];
                valid    <= 1'b1;
            end
        end
    end

`ifdef BUFFER_DE_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            nib_par <= 1'b0;
        end else begin
            nib_par <= out_win ? nib_parity(hold[nib_sel]) : 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_buffer_de.sv
// Randomized self-checking bench for buffer_de: a bit-stream model predicts every output
// each cycle, and literal nibble sequences pin the model on known frames.
module tb_buffer_de;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
    logic       data_in = 1'b0;
    logic [3:0] data_out;
    logic       valid;
    logic       frame_done;
`ifdef BUFFER_DE_PARITY_EN
    logic       nib_par;
`endif

    int checks = 0;
    int passed = 0;
    bit chk_en = 1'b0;

    buffer_de dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .data_in    (data_in),
        .data_out   (data_out),
        .valid      (valid),
        .frame_done (frame_done)
`ifdef BUFFER_DE_PARITY_EN
        ,
        .nib_par    (nib_par)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: every accepted bit since the start edge is kept in order; edge k outputs
    // nibble (k mod 64) of frame k/64-1 during the first 16 edges of each frame.
    bit         stream[$];
    bit         m_run = 1'b0;
    int         k;
    int         base;
    logic [3:0] exp_dout = 4'h0;
    logic       exp_valid = 1'b0;
    logic       exp_fd = 1'b0;
    logic       exp_par = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_run = 1'b0;
            stream.delete();
            exp_dout  = 4'h0;
            exp_valid = 1'b0;
            exp_fd    = 1'b0;
            exp_par   = 1'b0;
        end else if (m_run || ena) begin
            m_run = 1'b1;
            stream.push_back(data_in);
            k = stream.size() - 1;
            exp_fd    = (k % 64) == 63;
            exp_valid = (k >= 64) && ((k % 64) < 16);
            exp_par   = 1'b0;
            if (exp_valid) begin
                base     = (k / 64 - 1) * 64 + 4 * (k % 64);
                exp_dout = {stream[base+3], stream[base+2], stream[base+1], stream[base]};
                exp_par  = ^exp_dout;
            end
        end else begin
            exp_valid = 1'b0;
            exp_fd    = 1'b0;
            exp_par   = 1'b0;
        end
    end

    logic [3:0] got[$];
    logic       gotp[$];
    int         fd_count = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("valid", {63'd0, valid}, {63'd0, exp_valid});
            checkOutput("frame_done", {63'd0, frame_done}, {63'd0, exp_fd});
            checkOutput("data_out", {60'd0, data_out}, {60'd0, exp_dout});
`ifdef BUFFER_DE_PARITY_EN
            checkOutput("nib_par", {63'd0, nib_par}, {63'd0, exp_par});
            if (valid) gotp.push_back(nib_par);
`endif
            if (valid) got.push_back(data_out);
            if (frame_done) fd_count++;
        end
    end

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        ena = 1'b0;
        data_in = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("rst_valid", {63'd0, valid}, 64'd0);
        checkOutput("rst_frame_done", {63'd0, frame_done}, 64'd0);
        checkOutput("rst_data_out", {60'd0, data_out}, 64'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        got.delete();
        gotp.delete();
        fd_count = 0;
    endtask

    // Drives nbits of a frame LSB-first; ena is forced high on the start bit and random otherwise.
    task automatic applyStimulus(input logic [63:0] frame, input bit start, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            data_in = frame[i];
            ena = (start && i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ena = 1'b0;
            data_in = 1'($urandom_range(0, 1));
        end
    endtask

    // seq holds the expected emission order with the first nibble in the top bits.
    task automatic checkSeq(input string name, input int start, input logic [63:0] seq);
        logic [3:0] act;
        for (int j = 0; j < 16; j++) begin
            act = (start + j < got.size()) ? got[start+j] : 4'hx;
            checkOutput(name, {60'd0, act}, {60'd0, seq[63-4*j -: 4]});
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        // Known frames back to back with ena randomized while running.
        doReset();
        applyStimulus(64'h0123_4567_89AB_CDEF, 1'b1, 64);
        applyStimulus(64'hFFFF_0000_FFFF_0000, 1'b0, 64);
        applyStimulus(64'h5555_AAAA_5555_AAAA, 1'b0, 64);
        applyStimulus(rnd64(), 1'b0, 64);
        idleCycles(1);
        #1;
        checkSeq("frame0_nibs", 0, 64'hFEDC_BA98_7654_3210);
        checkSeq("frame1_nibs", 16, 64'h0000_FFFF_0000_FFFF);
        checkSeq("frame2_nibs", 32, 64'hAAAA_5555_AAAA_5555);
        checkOutput("b2b_frame_done_count", 64'(fd_count), 64'd4);

        // Never started: nothing may come out.
        doReset();
        idleCycles(100);
        #1;
        checkOutput("idle_nib_count", 64'(got.size()), 64'd0);
        checkOutput("idle_frame_done_count", 64'(fd_count), 64'd0);
        checkOutput("idle_data_out", {60'd0, data_out}, 64'd0);

        // Reset at frame cycle 40 of frame 1, then restart with a known frame.
        doReset();
        applyStimulus(rnd64(), 1'b1, 64);
        applyStimulus(rnd64(), 1'b0, 40);
        doReset();
        idleCycles(5);
        applyStimulus(64'hDEAD_BEEF_CAFE_F00D, 1'b1, 64);
        applyStimulus(rnd64(), 1'b0, 64);
        #1;
        checkOutput("restart_nib_count", 64'(got.size()), 64'd16);
        checkSeq("restart_nibs", 0, 64'hD00F_EFAC_FEEB_DAED);
        checkOutput("restart_frame_done_count", 64'(fd_count), 64'd1);

        // Reset landing on the last bit of frame 0 discards it entirely.
        doReset();
        applyStimulus(rnd64(), 1'b1, 63);
        doReset();
        idleCycles(80);
        #1;
        checkOutput("cut_nib_count", 64'(got.size()), 64'd0);
        checkOutput("cut_frame_done_count", 64'(fd_count), 64'd0);

        // Serializer loopback stream: nibbles 1..F,0 every frame.
        doReset();
        applyStimulus(64'h0FED_CBA9_8765_4321, 1'b1, 64);
        applyStimulus(64'h0FED_CBA9_8765_4321, 1'b0, 64);
        applyStimulus(64'h0FED_CBA9_8765_4321, 1'b0, 64);
        #1;
        checkSeq("loop_frame0", 0, 64'h1234_5678_9ABC_DEF0);
        checkSeq("loop_frame1", 16, 64'h1234_5678_9ABC_DEF0);

        // Parity frame: nibbles 1,7,F then zeros.
        doReset();
        applyStimulus(64'h0000_0000_0000_0F71, 1'b1, 64);
        applyStimulus(rnd64(), 1'b0, 64);
        #1;
        checkSeq("par_frame_nibs", 0, 64'h17F0_0000_0000_0000);
`ifdef BUFFER_DE_PARITY_EN
        begin
            logic [15:0] par_exp;
            logic        pact;
            par_exp = 16'b1100_0000_0000_0000;
            for (int j = 0; j < 16; j++) begin
                pact = (j < gotp.size()) ? gotp[j] : 1'bx;
                checkOutput("par_bits", {63'd0, pact}, {63'd0, par_exp[15-j]});
            end
        end
`endif

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
